bus_trace_tx: RTL and testbench

Parametrised bus-transaction tracer that feeds the UART transmitter. It snoops completed bus transactions (ack, address, data, direction) into an internal FIFO. It serialises each transaction as a framed, multi-byte record over a byte handshake to `uart_tx`, and counts records lost to overflow. It is the width/depth-generic, write-capable successor of the fixed 8-bit read logger and sits between the bus master's capture tap and the UART.

---
 rtl/ddk_trace_pkg.sv | 20 ++
 rtl/trace_fifo.sv | 73 +++++++
 rtl/bus_trace_tx.sv | 182 ++++++++++++++++++
 tb/tb_bus_trace_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddk_trace_pkg.sv
`default_nettype none
// ddk_trace_pkg : shared sync marker, serialiser states and byte-count helper for the bus tracer (rev 1.0)
package ddk_trace_pkg;

  localparam logic [3:0] TRACE_SYNC = 4'hA;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HDR  = 3'd2,
    ADR  = 3'd3,
    DAT  = 3'd4
  } trace_state_e;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// trace_fifo : single-clock FIFO with registered read data and count-derived full/empty (rev 1.0)
module trace_fifo
  import ddk_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = rd_data_q;
  assign level_o   = count_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: the count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_trace_tx.sv
`default_nettype none
// bus_trace_tx : snoops bus transactions into a FIFO and serialises framed records to a UART byte port (rev 1.0)
module bus_trace_tx
  import ddk_trace_pkg::*;
#(
  parameter int ADR_W          = 8,
  parameter int DAT_W          = 8,
  parameter int DEPTH          = 16,
  parameter int CAPTURE_WRITES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   cap_valid_i,
  input  logic                   cap_we_i,
  input  logic                   cap_ack_i,
  input  logic [ADR_W-1:0]       cap_adr_i,
  input  logic [DAT_W-1:0]       cap_dat_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_en_o,
  input  logic                   tx_rdy_i,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   overflow_o,
  output logic [7:0]             drop_cnt_o
);

  localparam int AB    = bytes_for(ADR_W);
  localparam int DB    = bytes_for(DAT_W);
  localparam int ENT_W = 3 + ADR_W + DAT_W;
  localparam int IDX_W = 3;

  trace_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d;
  logic             pend_loss_q, pend_loss_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             rec_we_q, rec_we_d, rec_ack_q, rec_ack_d, rec_lost_q, rec_lost_d;
  logic [ADR_W-1:0] rec_adr_q, rec_adr_d;
  logic [DAT_W-1:0] rec_dat_q, rec_dat_d;

  logic             cap_accept, fifo_push, fifo_drop, fifo_pop;
  logic             fifo_full, fifo_empty, send_ok;
  logic [ENT_W-1:0] fifo_wr, fifo_rd;
  logic [AB*8-1:0]  adr_ext;
  logic [DB*8-1:0]  dat_ext;
  logic [7:0]       adr_byte, dat_byte;

  assign cap_accept = cap_valid_i && (!cap_we_i || (CAPTURE_WRITES != 0));
  assign fifo_push  = cap_accept && !fifo_full;
  assign fifo_drop  = cap_accept && fifo_full;
  assign fifo_wr    = {cap_we_i, cap_ack_i, pend_loss_q, cap_adr_i, cap_dat_i};
  assign send_ok    = tx_rdy_i && !tx_en_q;

  trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .pop_i     (fifo_pop),
    .wr_data_i (fifo_wr),
    .rd_data_o (fifo_rd),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .level_o   (fifo_level_o)
  );

  always_comb begin
    adr_ext              = '0;
    adr_ext[ADR_W-1:0]   = rec_adr_q;
    dat_ext              = '0;
    dat_ext[DAT_W-1:0]   = rec_dat_q;
    adr_byte             = 8'(adr_ext >> {idx_q, 3'b000});
    dat_byte             = 8'(dat_ext >> {idx_q, 3'b000});
  end

  // Loss bookkeeping: a clear wins over a same-cycle drop but leaves the pending-loss flag alone.
  always_comb begin
    pend_loss_d = pend_loss_q;
    if (fifo_drop)      pend_loss_d = 1'b1;
    else if (fifo_push) pend_loss_d = 1'b0;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (fifo_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = 1'b0;
    fifo_pop   = 1'b0;
    rec_we_d   = rec_we_q;
    rec_ack_d  = rec_ack_q;
    rec_lost_d = rec_lost_q;
    rec_adr_d  = rec_adr_q;
    rec_dat_d  = rec_dat_q;
    case (state_q)
      IDLE: if (tx_rdy_i && !fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = LOAD;
      end
      LOAD: if (tx_rdy_i) begin
        rec_we_d   = fifo_rd[ENT_W-1];
        rec_ack_d  = fifo_rd[ENT_W-2];
        rec_lost_d = fifo_rd[ENT_W-3];
        rec_adr_d  = fifo_rd[DAT_W +: ADR_W];
        rec_dat_d  = fifo_rd[DAT_W-1:0];
        state_d    = HDR;
      end
      HDR: if (send_ok) begin
        tx_data_d = {TRACE_SYNC, rec_we_q, rec_ack_q, rec_lost_q, 1'b0};
        tx_en_d   = 1'b1;
        idx_d     = IDX_W'(AB - 1);
        state_d   = ADR;
      end
      ADR: if (send_ok) begin
        tx_data_d = adr_byte;
        tx_en_d   = 1'b1;
        if (idx_q == '0) begin
          idx_d   = IDX_W'(DB - 1);
          state_d = DAT;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DAT: if (send_ok) begin
        tx_data_d = dat_byte;
        tx_en_d   = 1'b1;
        if (idx_q == '0) state_d = IDLE;
        else             idx_d   = idx_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      pend_loss_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      rec_we_q    <= 1'b0;
      rec_ack_q   <= 1'b0;
      rec_lost_q  <= 1'b0;
      rec_adr_q   <= '0;
      rec_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      pend_loss_q <= pend_loss_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      rec_we_q    <= rec_we_d;
      rec_ack_q   <= rec_ack_d;
      rec_lost_q  <= rec_lost_d;
      rec_adr_q   <= rec_adr_d;
      rec_dat_q   <= rec_dat_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_en_o    = tx_en_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_trace_tx.sv
`default_nettype none
// tb_bus_trace_tx : self-checking bench; instance A uses defaults, instance B is 12/16-bit, depth 4, writes captured (rev 1.0)
module tb_bus_trace_tx;

  logic clk = 1'b0;
  logic rst, clr;

  logic       a_valid, a_we, a_ack, a_rdy;
  logic [7:0] a_adr, a_dat, a_txd, a_drop;
  logic       a_txen, a_ovf;
  logic [4:0] a_lvl;

  logic        b_valid, b_we, b_ack, b_rdy;
  logic [11:0] b_adr;
  logic [15:0] b_dat;
  logic [7:0]  b_txd, b_drop;
  logic        b_txen, b_ovf;
  logic [2:0]  b_lvl;

  int n_vec = 0;
  int n_err = 0;
  int a_proto = 0;
  int b_proto = 0;
  logic a_en_prev = 1'b0, a_rdy_prev = 1'b0, b_en_prev = 1'b0, b_rdy_prev = 1'b0;

  byte unsigned a_got[$], a_exp[$], b_got[$], b_exp[$];

  always #5 clk = ~clk;

  bus_trace_tx u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .cap_valid_i(a_valid), .cap_we_i(a_we), .cap_ack_i(a_ack),
    .cap_adr_i(a_adr), .cap_dat_i(a_dat),
    .tx_data_o(a_txd), .tx_en_o(a_txen), .tx_rdy_i(a_rdy),
    .fifo_level_o(a_lvl), .overflow_o(a_ovf), .drop_cnt_o(a_drop)
  );

  bus_trace_tx #(.ADR_W(12), .DAT_W(16), .DEPTH(4), .CAPTURE_WRITES(1)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .cap_valid_i(b_valid), .cap_we_i(b_we), .cap_ack_i(b_ack),
    .cap_adr_i(b_adr), .cap_dat_i(b_dat),
    .tx_data_o(b_txd), .tx_en_o(b_txen), .tx_rdy_i(b_rdy),
    .fifo_level_o(b_lvl), .overflow_o(b_ovf), .drop_cnt_o(b_drop)
  );

  // Byte collectors plus handshake rule watchers (strobe needs ready the cycle before, never back to back).
  always @(negedge clk) begin
    if (a_txen) begin
      a_got.push_back(a_txd);
      if (a_en_prev || !a_rdy_prev) a_proto <= a_proto + 1;
    end
    if (b_txen) begin
      b_got.push_back(b_txd);
      if (b_en_prev || !b_rdy_prev) b_proto <= b_proto + 1;
    end
    a_en_prev  <= a_txen;
    a_rdy_prev <= a_rdy;
    b_en_prev  <= b_txen;
    b_rdy_prev <= b_rdy;
  end

  // Reference record: header, address bytes MSB first, data bytes MSB first.
  function automatic void add_rec(input bit to_b, input bit we, input bit ack, input bit lost,
                                  input logic [31:0] adr, input logic [31:0] dat,
                                  input int ab, input int db);
    byte unsigned q[$];
    q.push_back({4'hA, we, ack, lost, 1'b0});
    for (int i = ab - 1; i >= 0; i--) q.push_back(8'(adr >> (8 * i)));
    for (int i = db - 1; i >= 0; i--) q.push_back(8'(dat >> (8 * i)));
    foreach (q[k]) begin
      if (to_b) b_exp.push_back(q[k]);
      else      a_exp.push_back(q[k]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_a(input bit we, input bit ack, input logic [7:0] adr, input logic [7:0] dat);
    a_we = we; a_ack = ack; a_adr = adr; a_dat = dat; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_we = 1'b0;
  endtask

  task automatic cap_b(input bit we, input bit ack, input logic [11:0] adr, input logic [15:0] dat);
    b_we = we; b_ack = ack; b_adr = adr; b_dat = dat; b_valid = 1'b1;
    tick();
    b_valid = 1'b0; b_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    a_valid = 0; a_we = 0; a_ack = 0; a_rdy = 0; a_adr = 0; a_dat = 0;
    b_valid = 0; b_we = 0; b_ack = 0; b_rdy = 0; b_adr = 0; b_dat = 0;
    repeat (3) tick();
    n_vec++; if (a_txen !== 1'b0)  begin n_err++; $display("FAIL reset_a_tx_en got %0b want 0", a_txen); end
    n_vec++; if (a_txd !== 8'h00)  begin n_err++; $display("FAIL reset_a_tx_data got %h want 00", a_txd); end
    n_vec++; if (a_lvl !== 5'd0)   begin n_err++; $display("FAIL reset_a_level got %0d want 0", a_lvl); end
    n_vec++; if (a_ovf !== 1'b0)   begin n_err++; $display("FAIL reset_a_overflow got %0b want 0", a_ovf); end
    n_vec++; if (a_drop !== 8'd0)  begin n_err++; $display("FAIL reset_a_drop got %0d want 0", a_drop); end
    n_vec++; if (b_txen !== 1'b0)  begin n_err++; $display("FAIL reset_b_tx_en got %0b want 0", b_txen); end
    n_vec++; if (b_lvl !== 3'd0)   begin n_err++; $display("FAIL reset_b_level got %0d want 0", b_lvl); end
    n_vec++; if (b_drop !== 8'd0)  begin n_err++; $display("FAIL reset_b_drop got %0d want 0", b_drop); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a_rdy = 1'b1;
    a_got.delete(); a_exp.delete();
    add_rec(0, 0, 1, 0, 32'h12, 32'h34, 1, 1);
    cap_a(0, 1, 8'h12, 8'h34);
    n_vec++; if (a_lvl !== 5'd1) begin n_err++; $display("FAIL basic_level got %0d want 1", a_lvl); end
    tick(); tick();
    n_vec++; if (a_txen !== 1'b0) begin n_err++; $display("FAIL basic_early_strobe got %0b want 0", a_txen); end
    tick();
    n_vec++; if (a_txen !== 1'b1 || a_txd !== 8'hA4)
      begin n_err++; $display("FAIL basic_hdr_cycle4 got en=%0b data=%h want en=1 data=a4", a_txen, a_txd); end
    for (int c = 0; c < 100 && a_got.size() < a_exp.size(); c++) tick();
    n_vec++; if (a_got.size() != a_exp.size())
      begin n_err++; $display("FAIL basic_count got %0d want %0d", a_got.size(), a_exp.size()); end
    for (int i = 0; i < a_exp.size(); i++) begin
      n_vec++;
      if (i >= a_got.size() || a_got[i] !== a_exp[i])
        begin n_err++; $display("FAIL basic_byte%0d got %h want %h", i, (i < a_got.size()) ? a_got[i] : 8'h00, a_exp[i]); end
    end
  endtask

  task automatic test_wide();
    b_rdy = 1'b1;
    b_got.delete(); b_exp.delete();
    add_rec(1, 0, 0, 0, 32'hABC, 32'hBEEF, 2, 2);
    cap_b(0, 0, 12'hABC, 16'hBEEF);
    for (int c = 0; c < 100 && b_got.size() < b_exp.size(); c++) tick();
    n_vec++; if (b_got.size() != 5)
      begin n_err++; $display("FAIL wide_count got %0d want 5", b_got.size()); end
    for (int i = 0; i < b_exp.size(); i++) begin
      n_vec++;
      if (i >= b_got.size() || b_got[i] !== b_exp[i])
        begin n_err++; $display("FAIL wide_byte%0d got %h want %h", i, (i < b_got.size()) ? b_got[i] : 8'h00, b_exp[i]); end
    end
  endtask

  task automatic test_writes();
    a_got.delete();
    cap_a(1, 1, 8'h01, 8'h02);
    n_vec++; if (a_lvl !== 5'd0) begin n_err++; $display("FAIL write_ignored_level got %0d want 0", a_lvl); end
    repeat (10) tick();
    n_vec++; if (a_got.size() != 0) begin n_err++; $display("FAIL write_ignored_bytes got %0d want 0", a_got.size()); end
    b_rdy = 1'b1;
    b_got.delete(); b_exp.delete();
    add_rec(1, 1, 1, 0, 32'h01, 32'h02, 2, 2);
    cap_b(1, 1, 12'h001, 16'h0002);
    for (int c = 0; c < 100 && b_got.size() < b_exp.size(); c++) tick();
    n_vec++; if (b_got.size() != b_exp.size())
      begin n_err++; $display("FAIL write_count got %0d want %0d", b_got.size(), b_exp.size()); end
    for (int i = 0; i < b_exp.size(); i++) begin
      n_vec++;
      if (i >= b_got.size() || b_got[i] !== b_exp[i])
        begin n_err++; $display("FAIL write_byte%0d got %h want %h", i, (i < b_got.size()) ? b_got[i] : 8'h00, b_exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] adr;
    logic [15:0] dat;
    bit          ack;
    b_rdy = 1'b0;
    b_got.delete(); b_exp.delete();
    for (int i = 0; i < 6; i++) begin
      adr = 12'($urandom); dat = 16'($urandom); ack = 1'($urandom);
      if (i < 4) add_rec(1, 0, ack, 0, 32'(adr), 32'(dat), 2, 2);
      cap_b(0, ack, adr, dat);
    end
    n_vec++; if (b_lvl !== 3'd4)  begin n_err++; $display("FAIL ovf_level got %0d want 4", b_lvl); end
    n_vec++; if (b_drop !== 8'd2) begin n_err++; $display("FAIL ovf_drop got %0d want 2", b_drop); end
    n_vec++; if (b_ovf !== 1'b1)  begin n_err++; $display("FAIL ovf_flag got %0b want 1", b_ovf); end
    b_rdy = 1'b1;
    for (int c = 0; c < 300 && b_got.size() < b_exp.size(); c++) tick();
    n_vec++; if (b_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", b_ovf); end
    add_rec(1, 0, 1, 1, 32'h123, 32'h4567, 2, 2);
    cap_b(0, 1, 12'h123, 16'h4567);
    for (int c = 0; c < 300 && b_got.size() < b_exp.size(); c++) tick();
    n_vec++; if (b_got.size() != 25 || b_got[20] !== 8'hA6)
      begin n_err++; $display("FAIL ovf_lost_hdr got size=%0d hdr=%h want size=25 hdr=a6", b_got.size(), (b_got.size() > 20) ? b_got[20] : 8'h00); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_vec++; if (b_drop !== 8'd0 || b_ovf !== 1'b0)
      begin n_err++; $display("FAIL clr got drop=%0d ovf=%0b want 0 0", b_drop, b_ovf); end
    // Refill, then drop in the same cycle as a clear; the loss must still mark the next record.
    b_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adr = 12'($urandom); dat = 16'($urandom);
      add_rec(1, 0, 0, 0, 32'(adr), 32'(dat), 2, 2);
      cap_b(0, 0, adr, dat);
    end
    clr = 1'b1;
    cap_b(0, 0, 12'h0FF, 16'h00FF);
    clr = 1'b0;
    n_vec++; if (b_drop !== 8'd0 || b_ovf !== 1'b0)
      begin n_err++; $display("FAIL clr_beats_drop got drop=%0d ovf=%0b want 0 0", b_drop, b_ovf); end
    b_rdy = 1'b1;
    for (int c = 0; c < 300 && b_got.size() < 45; c++) tick();
    add_rec(1, 0, 0, 1, 32'h321, 32'h7654, 2, 2);
    cap_b(0, 0, 12'h321, 16'h7654);
    for (int c = 0; c < 300 && b_got.size() < b_exp.size(); c++) tick();
    n_vec++; if (b_got.size() != b_exp.size())
      begin n_err++; $display("FAIL ovf_count got %0d want %0d", b_got.size(), b_exp.size()); end
    for (int i = 0; i < b_exp.size(); i++) begin
      n_vec++;
      if (i >= b_got.size() || b_got[i] !== b_exp[i])
        begin n_err++; $display("FAIL ovf_byte%0d got %h want %h", i, (i < b_got.size()) ? b_got[i] : 8'h00, b_exp[i]); end
    end
  endtask

  task automatic test_random_ready();
    int   base;
    bit   we, ack;
    logic [7:0] adr, dat;
    base = a_proto;
    a_got.delete(); a_exp.delete();
    for (int r = 0; r < 20; r++) begin
      we = ($urandom_range(0, 3) == 0);
      ack = 1'($urandom);
      adr = 8'($urandom); dat = 8'($urandom);
      if (!we) add_rec(0, 0, ack, 0, 32'(adr), 32'(dat), 1, 1);
      a_rdy = ($urandom_range(0, 9) < 6);
      cap_a(we, ack, adr, dat);
      repeat (9) begin a_rdy = ($urandom_range(0, 9) < 6); tick(); end
    end
    for (int c = 0; c < 2000 && a_got.size() < a_exp.size(); c++) begin
      a_rdy = ($urandom_range(0, 9) < 6); tick();
    end
    a_rdy = 1'b1;
    repeat (3) tick();
    n_vec++; if (a_got.size() != a_exp.size())
      begin n_err++; $display("FAIL rand_count got %0d want %0d", a_got.size(), a_exp.size()); end
    for (int i = 0; i < a_exp.size(); i++) begin
      n_vec++;
      if (i >= a_got.size() || a_got[i] !== a_exp[i])
        begin n_err++; $display("FAIL rand_byte%0d got %h want %h", i, (i < a_got.size()) ? a_got[i] : 8'h00, a_exp[i]); end
    end
    n_vec++; if (a_proto != base)
      begin n_err++; $display("FAIL rand_handshake got %0d violations want 0", a_proto - base); end
    n_vec++; if (a_drop !== 8'd0) begin n_err++; $display("FAIL rand_drop got %0d want 0", a_drop); end
  endtask

  task automatic test_reset_mid();
    a_rdy = 1'b1;
    a_got.delete(); a_exp.delete();
    cap_a(0, 1, 8'h55, 8'h66);
    cap_a(0, 1, 8'h99, 8'hAA);
    for (int c = 0; c < 50 && a_got.size() < 2; c++) tick();
    n_vec++; if (a_got.size() != 2 || a_got[1] !== 8'h55)
      begin n_err++; $display("FAIL mid_adr_byte got size=%0d want size=2 byte=55", a_got.size()); end
    rst = 1'b1;
    #1;
    n_vec++; if (a_txen !== 1'b0 || a_txd !== 8'h00 || a_lvl !== 5'd0)
      begin n_err++; $display("FAIL mid_reset_outputs got en=%0b data=%h lvl=%0d want 0 00 0", a_txen, a_txd, a_lvl); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    n_vec++; if (a_got.size() != 2)
      begin n_err++; $display("FAIL mid_no_more_bytes got %0d want 2", a_got.size()); end
    a_got.delete();
    add_rec(0, 0, 0, 0, 32'h77, 32'h88, 1, 1);
    cap_a(0, 0, 8'h77, 8'h88);
    for (int c = 0; c < 100 && a_got.size() < a_exp.size(); c++) tick();
    n_vec++; if (a_got.size() != a_exp.size())
      begin n_err++; $display("FAIL mid_fresh_count got %0d want %0d", a_got.size(), a_exp.size()); end
    for (int i = 0; i < a_exp.size(); i++) begin
      n_vec++;
      if (i >= a_got.size() || a_got[i] !== a_exp[i])
        begin n_err++; $display("FAIL mid_fresh_byte%0d got %h want %h", i, (i < a_got.size()) ? a_got[i] : 8'h00, a_exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_writes();
    test_overflow();
    test_random_ready();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
